// File: rtl/branch_predict_hybrid.sv
// ---------------------------------------------------------------------------
// branch_predict_hybrid
//
// Conditional-branch direction predictor with three build-time modes:
//   MODE 0 : local two-level (per-PC history table -> local PHT)
//   MODE 1 : gshare (global history XOR PC -> global PHT)
//   MODE 2 : tournament (local vs gshare, picked by a per-PC chooser)
//
// The prediction is looked up combinationally in F, registered into D and
// qualified there by the decoder's branch flag. All tables are trained from
// the M stage, only for real branches, so wrong-path fetches never pollute
// them.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   flushD        clear the F->D prediction register (wins over stallD)
//   stallD        hold the F->D prediction register
//   pcF           fetch PC (lookup address)
//   pcM           PC of the branch resolving in M (training address)
//   branchD       instruction in D is a conditional branch
//   branchM       instruction in M is a conditional branch (training enable)
//   actual_takeM  resolved direction of the M branch
//   pred_takeF    raw F-stage prediction (combinational)
//   pred_takeD    final D-stage prediction (branchD & registered pred_takeF)
// ---------------------------------------------------------------------------
module branch_predict_hybrid #(
    parameter int MODE       = 2,
    parameter int PHT_DEPTH  = 6,
    parameter int BHT_DEPTH  = 10,
    parameter int CPHT_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flushD,
    input  logic        stallD,
    input  logic [31:0] pcF,
    input  logic [31:0] pcM,
    input  logic        branchD,
    input  logic        branchM,
    input  logic        actual_takeM,
    output logic        pred_takeF,
    output logic        pred_takeD
);

    // Gray-style 2-bit counter: the MSB is the predicted direction and only
    // one bit flips per step.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b11,
        CTR_ST  = 2'b10
    } ctr_e;

    function automatic logic [1:0] ctr_step(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
        endcase
        return nxt;
    endfunction

    // PC-derived indices; word-aligned PCs, so bits [1:0] never index.
    logic [BHT_DEPTH-1:0]  bidx_f, bidx_m;
    logic [PHT_DEPTH-1:0]  pidx_f, pidx_m;
    logic [CPHT_DEPTH-1:0] cidx_f, cidx_m;

    assign bidx_f = pcF[BHT_DEPTH+1:2];
    assign bidx_m = pcM[BHT_DEPTH+1:2];
    assign pidx_f = pcF[PHT_DEPTH+1:2];
    assign pidx_m = pcM[PHT_DEPTH+1:2];
    assign cidx_f = pcF[CPHT_DEPTH+1:2];
    assign cidx_m = pcM[CPHT_DEPTH+1:2];

    // Component predictions at the F (lookup) and M (training) addresses.
    logic local_f, local_m;
    logic global_f, global_m;
    logic sel_global_f;

    generate
        if (MODE != 1) begin : g_local
            logic [PHT_DEPTH-1:0] bht_q   [0:(1 << BHT_DEPTH)-1];
            logic [1:0]           pht_l_q [0:(1 << PHT_DEPTH)-1];
            logic [PHT_DEPTH-1:0] lidx_f, lidx_m;
            logic [PHT_DEPTH-1:0] bht_d;
            logic [1:0]           pht_l_d;

            assign lidx_f  = bht_q[bidx_f];
            assign lidx_m  = bht_q[bidx_m];
            assign local_f = pht_l_q[lidx_f][1];
            assign local_m = pht_l_q[lidx_m][1];
            assign bht_d   = {bht_q[bidx_m][PHT_DEPTH-2:0], actual_takeM};
            assign pht_l_d = ctr_step(pht_l_q[lidx_m], actual_takeM);

            // NOTE: the tables must come out of reset in a known state, so they
            // are flop arrays with an async reset rather than an inferred RAM.
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values; this is also what gives the F read
            // the old entry when it collides with an M update.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < (1 << BHT_DEPTH); i++) bht_q[i] <= '0;
                    for (int i = 0; i < (1 << PHT_DEPTH); i++) pht_l_q[i] <= CTR_WT;
                end else if (branchM) begin
                    bht_q[bidx_m]   <= bht_d;
                    pht_l_q[lidx_m] <= pht_l_d;
                end
            end
        end else begin : g_no_local
            assign local_f = 1'b0;
            assign local_m = 1'b0;
        end

        if (MODE != 0) begin : g_global
            logic [PHT_DEPTH-1:0] ghr_q, ghr_d;
            logic [1:0]           pht_g_q [0:(1 << PHT_DEPTH)-1];
            logic [PHT_DEPTH-1:0] gidx_f, gidx_m;
            logic [1:0]           pht_g_d;

            assign gidx_f   = ghr_q ^ pidx_f;
            assign gidx_m   = ghr_q ^ pidx_m;
            assign global_f = pht_g_q[gidx_f][1];
            assign global_m = pht_g_q[gidx_m][1];
            assign ghr_d    = {ghr_q[PHT_DEPTH-2:0], actual_takeM};
            assign pht_g_d  = ctr_step(pht_g_q[gidx_m], actual_takeM);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ghr_q <= '0;
                    for (int i = 0; i < (1 << PHT_DEPTH); i++) pht_g_q[i] <= CTR_WT;
                end else if (branchM) begin
                    ghr_q           <= ghr_d;
                    pht_g_q[gidx_m] <= pht_g_d;
                end
            end
        end else begin : g_no_global
            assign global_f = 1'b0;
            assign global_m = 1'b0;
        end

        if (MODE == 2) begin : g_chooser
            // Plain saturating binary counter: 00/01 favour local, 10/11 global.
            logic [1:0] cpht_q [0:(1 << CPHT_DEPTH)-1];
            logic [1:0] cpht_d;

            assign sel_global_f = cpht_q[cidx_f][1];

            // NOTE: always_comb assigns a default first so no path leaves the
            // output unassigned and no latch is inferred.
            always_comb begin
                cpht_d = cpht_q[cidx_m];
                if (global_m == actual_takeM) begin
                    if (cpht_d != 2'b11) cpht_d = cpht_d + 2'd1;
                end else if (cpht_d != 2'b00) begin
                    cpht_d = cpht_d - 2'd1;
                end
            end

            // Only a disagreement carries information about which side is better.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < (1 << CPHT_DEPTH); i++) cpht_q[i] <= 2'b01;
                end else if (branchM && (local_m != global_m)) begin
                    cpht_q[cidx_m] <= cpht_d;
                end
            end
        end else begin : g_no_chooser
            assign sel_global_f = 1'b0;
        end
    endgenerate

    always_comb begin
        if (MODE == 0)      pred_takeF = local_f;
        else if (MODE == 1) pred_takeF = global_f;
        else                pred_takeF = sel_global_f ? global_f : local_f;
    end

    // F->D prediction register: flush beats stall.
    logic pred_take_q, pred_take_d;

    always_comb begin
        pred_take_d = pred_take_q;
        if (flushD)       pred_take_d = 1'b0;
        else if (!stallD) pred_take_d = pred_takeF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pred_take_q <= 1'b0;
        else     pred_take_q <= pred_take_d;
    end

    assign pred_takeD = branchD & pred_take_q;

    // PC bits outside every index window, and M-side predictions that a
    // single-table mode never consumes, are intentionally dropped here.
    logic unused_ok;
    assign unused_ok = ^{pcF, pcM, bidx_f, bidx_m, pidx_f, pidx_m,
                         cidx_f, cidx_m, local_m, global_m};

endmodule
